// File: rtl/cpu_step_ctrl.sv
// Turns the divided slow clock into single-cycle CPU advance pulses, gated by
// run switch, debounced single-step button and CPU halt request.
module cpu_step_ctrl #(
  parameter int unsigned DEBOUNCE = 1_000_000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_in,
  input  logic             run_sw,
  input  logic             step_btn,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic             halted,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE);

  typedef enum logic [1:0] {
    S_HALTED,
    S_RUNNING,
    S_STEP_WAIT
  } state_t;

  logic            r_s1, r_s2, r_s3;
  logic            w_tick;
  logic            r_run1, r_run_s;
  logic            r_btn1, r_btn_s;
  logic            r_db_level;
  logic [DB_W-1:0] r_db_cnt;
  logic            r_step_req;
  state_t          r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_run1  <= 1'b0;
      r_run_s <= 1'b0;
      r_btn1  <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_s1    <= slow_in;
      r_s2    <= r_s1;
      r_s3    <= r_s2;
      r_run1  <= run_sw;
      r_run_s <= r_run1;
      r_btn1  <= step_btn;
      r_btn_s <= r_btn1;
    end
  end

  assign w_tick = r_s2 & ~r_s3;

  // Level is accepted after DEBOUNCE consecutive cycles away from the stable value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_cnt   <= '0;
      r_db_level <= 1'b0;
      r_step_req <= 1'b0;
    end else begin
      r_step_req <= 1'b0;
      if (r_btn_s == r_db_level) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_W'(DEBOUNCE - 1)) begin
        r_db_level <= r_btn_s;
        r_db_cnt   <= '0;
        r_step_req <= r_btn_s;
      end else begin
        r_db_cnt <= r_db_cnt + DB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_HALTED;
      cpu_en     <= 1'b0;
      halted     <= 1'b1;
      step_count <= '0;
    end else begin
      cpu_en <= 1'b0;
      case (r_state)
        S_HALTED: begin
          if (!halt_req) begin
            if (r_run_s) begin
              r_state <= S_RUNNING;
              halted  <= 1'b0;
            end else if (r_step_req) begin
              r_state <= S_STEP_WAIT;
              halted  <= 1'b0;
            end
          end
        end
        S_RUNNING: begin
          if (halt_req || !r_run_s) begin
            r_state <= S_HALTED;
            halted  <= 1'b1;
          end else if (w_tick) begin
            cpu_en     <= 1'b1;
            step_count <= step_count + CNT_W'(1);
          end
        end
        S_STEP_WAIT: begin
          if (halt_req) begin
            r_state <= S_HALTED;
            halted  <= 1'b1;
          end else if (r_run_s) begin
            r_state <= S_RUNNING;
          end else if (w_tick) begin
            cpu_en     <= 1'b1;
            step_count <= step_count + CNT_W'(1);
            r_state    <= S_HALTED;
            halted     <= 1'b1;
          end
        end
        default: begin
          r_state <= S_HALTED;
          halted  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: directed scenarios plus randomized traffic, all
// checked every cycle against a sample-history reference model.
module tb_cpu_step_ctrl;

  localparam int DEB = 4;
  localparam int CW  = 4;
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          slow_in = 1'b0, run_sw = 1'b0, step_btn = 1'b0, halt_req = 1'b0;
  logic          cpu_en, halted;
  logic [CW-1:0] step_count;

  int errors = 0, checks = 0, n_pulses = 0;

  cpu_step_ctrl #(.DEBOUNCE(DEB), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .slow_in(slow_in), .run_sw(run_sw),
    .step_btn(step_btn), .halt_req(halt_req), .cpu_en(cpu_en),
    .halted(halted), .step_count(step_count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: index 0 of each history is the newest sample.
  bit slow_q[$], run_q[$], btn_q[$];
  int m_mode, m_cnt, m_diff;
  bit m_en, m_level, m_step_req;

  function automatic void m_clear();
    slow_q.delete(); run_q.delete(); btn_q.delete();
    for (int i = 0; i < 3; i++) begin
      slow_q.push_back(1'b0); run_q.push_back(1'b0); btn_q.push_back(1'b0);
    end
    m_mode = M_HALT; m_cnt = 0; m_diff = 0;
    m_en = 1'b0; m_level = 1'b0; m_step_req = 1'b0;
  endfunction

  function automatic void m_step();
    bit tick, run_s, bs, req;
    tick  = slow_q[1] && !slow_q[2];
    run_s = run_q[1];
    bs    = btn_q[1];
    req   = m_step_req;
    m_en  = 1'b0;
    if (m_mode == M_HALT) begin
      if (!halt_req && run_s) m_mode = M_RUN;
      else if (!halt_req && req) m_mode = M_STEP;
    end else if (m_mode == M_RUN) begin
      if (halt_req || !run_s) m_mode = M_HALT;
      else if (tick) m_en = 1'b1;
    end else begin
      if (halt_req) m_mode = M_HALT;
      else if (run_s) m_mode = M_RUN;
      else if (tick) begin m_en = 1'b1; m_mode = M_HALT; end
    end
    if (m_en) m_cnt = (m_cnt + 1) % (1 << CW);
    m_step_req = 1'b0;
    if (bs == m_level) m_diff = 0;
    else begin
      m_diff++;
      if (m_diff == DEB) begin
        m_level = bs; m_diff = 0; m_step_req = bs;
      end
    end
    slow_q.push_front(slow_in); void'(slow_q.pop_back());
    run_q.push_front(run_sw);   void'(run_q.pop_back());
    btn_q.push_front(step_btn); void'(btn_q.pop_back());
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_clear();
    else m_step();
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cpu_en", cpu_en, m_en);
      chk("halted", halted, m_mode == M_HALT);
      chk("step_count", step_count, m_cnt);
      if (cpu_en) n_pulses++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; slow_in = 1'b0; run_sw = 1'b0; step_btn = 1'b0; halt_req = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic slow_pulse(input int hi, input int lo);
    slow_in = 1'b1; cyc(hi);
    slow_in = 1'b0; cyc(lo);
  endtask

  task automatic press(input int hold, input int rel);
    step_btn = 1'b1; cyc(hold);
    step_btn = 1'b0; cyc(rel);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    int p0, lat, slow_left, btn_left;
    int bounce[12];

    // Reset state and mid-run reset with a pulse pending
    do_reset();
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_halted", halted, 1);
    chk("rst_step_count", step_count, 0);
    run_sw = 1'b1; cyc(4);
    slow_pulse(6, 6); slow_pulse(6, 6);
    chk("pre_rst_count", step_count, 2);
    slow_in = 1'b1; cyc(2);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_cpu_en", cpu_en, 0);
    chk("midrst_halted", halted, 1);
    chk("midrst_count", step_count, 0);
    run_sw = 1'b0;
    cyc(2); rst_n = 1'b1;
    cyc(4); slow_in = 1'b0; cyc(4);
    p0 = n_pulses;
    repeat (10) slow_pulse(5, 5);
    cyc(3);
    chk("halted_no_pulses", n_pulses - p0, 0);

    // Free run: latency and pulse count
    do_reset();
    run_sw = 1'b1; cyc(4);
    p0 = n_pulses; lat = 0;
    slow_in = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (cpu_en && lat == 0) lat = k;
    end
    slow_in = 1'b0; cyc(10);
    chk("latency_edges", lat, 3);
    repeat (4) slow_pulse(10, 10);
    cyc(3);
    chk("freerun_pulses", n_pulses - p0, 5);
    chk("freerun_count", step_count, 5);

    // Single step with a bouncy button
    do_reset();
    bounce = '{1, 1, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0};
    foreach (bounce[i]) begin step_btn = bounce[i][0]; cyc(1); end
    cyc(4);
    chk("bounce_ignored", halted, 1);
    press(10, 10);
    chk("step_armed", halted, 0);
    p0 = n_pulses;
    slow_pulse(6, 6);
    chk("step_one_pulse", n_pulses - p0, 1);
    chk("step_halted", halted, 1);
    chk("step_count1", step_count, 1);
    slow_pulse(6, 6);
    chk("step_no_more", n_pulses - p0, 1);
    press(8, 8);
    slow_pulse(6, 6);
    chk("step_count2", step_count, 2);

    // Halt priority over a coincident tick
    do_reset();
    run_sw = 1'b1; cyc(4);
    p0 = n_pulses;
    slow_in = 1'b1; cyc(2);
    halt_req = 1'b1; cyc(1);
    chk("halt_cpu_en", cpu_en, 0);
    chk("halt_halted", halted, 1);
    cyc(9); slow_in = 1'b0; cyc(5);
    slow_pulse(5, 5);
    chk("halt_held", halted, 1);
    chk("halt_no_pulse", n_pulses - p0, 0);
    halt_req = 1'b0; cyc(3);
    chk("halt_release_run", halted, 0);
    slow_pulse(6, 6);
    chk("halt_resume", n_pulses - p0, 1);

    // Counter wrap
    do_reset();
    run_sw = 1'b1; cyc(4);
    for (int i = 1; i <= 17; i++) begin
      slow_pulse(4, 4);
      if (i == 15) chk("wrap_15", step_count, 15);
      if (i == 16) chk("wrap_0", step_count, 0);
      if (i == 17) chk("wrap_1", step_count, 1);
    end

    // Step requests while waiting; run switch during STEP_WAIT
    do_reset();
    p0 = n_pulses;
    press(8, 8);
    chk("sw_wait1", halted, 0);
    press(8, 8);
    slow_pulse(6, 6); slow_pulse(6, 6);
    chk("sw_single", n_pulses - p0, 1);
    chk("sw_halted", halted, 1);
    press(8, 8);
    run_sw = 1'b1; cyc(4);
    chk("sw_run_state", halted, 0);
    chk("sw_run_nopulse", n_pulses - p0, 1);
    slow_pulse(6, 6);
    chk("sw_run_pulse", n_pulses - p0, 2);

    // Randomized traffic
    do_reset();
    slow_left = 3; btn_left = 5;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (slow_left == 0) begin
        slow_in = ~slow_in; slow_left = $urandom_range(12, 1);
      end else slow_left--;
      if (btn_left == 0) begin
        step_btn = ~step_btn; btn_left = $urandom_range(14, 0);
      end else btn_left--;
      if ($urandom_range(149, 0) == 0) run_sw = ~run_sw;
      if ($urandom_range(39, 0) == 0) halt_req = ~halt_req;
      if ($urandom_range(799, 0) == 0) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rnd_rst_cpu_en", cpu_en, 0);
        chk("rnd_rst_halted", halted, 1);
        chk("rnd_rst_count", step_count, 0);
        @(negedge clk) rst_n = 1'b1;
      end
    end
    cyc(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
